// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store bus sequencer between the execute stage and the data-memory
//   bus. Accepts one load or store per request, checks alignment, drives a
//   big-endian req/ack bus cycle with wait states and timeout, and holds the
//   pipeline until the access completes. For loads it captures the raw word
//   and latches offset/size/extension for the downstream read-data decoder.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   memRead, memWrite            access request (memWrite has priority)
//   addr, wrData                 byte address, right-justified store data
//   dataSize, bitExt             0 word / 1 half / 2 byte / 3 reserved; ext ctrl
//   stall                        freeze the pipeline (combinational)
//   done, addrErr, busErr        one-cycle completion / error pulses
//   busReq, busWe, busAddr,
//   busWrData, busByteEn         registered bus request outputs
//   busAck, busRdData            bus response
//   rdWord, rdOffset, rdSize,
//   rdBitExt, rdValid            captured load word and decoder controls
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wrData,
    input  logic [1:0]  dataSize,
    input  logic        bitExt,
    output logic        stall,
    output logic        done,
    output logic        addrErr,
    output logic        busErr,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWrData,
    output logic [3:0]  busByteEn,
    input  logic        busAck,
    input  logic [31:0] busRdData,
    output logic [31:0] rdWord,
    output logic [1:0]  rdOffset,
    output logic [1:0]  rdSize,
    output logic        rdBitExt,
    output logic        rdValid
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter value seen during the TIMEOUT-th REQ cycle (cleared on entry).
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] toCnt;
    logic             accessLoad;   // current/last access was a load
    logic             errBus;       // ERR cause: 1 = timeout, 0 = alignment
    logic             reqValid;
    logic             misaligned;
    logic             timeoutHit;

    // Big-endian lane enables: lane 3 (bit 3) carries data[31:24].
    function automatic logic [3:0] laneEnable(input logic [1:0] size,
                                              input logic [1:0] off);
        logic [3:0] en;
        case (size)
            2'd0:    en = 4'b1111;
            2'd1:    en = off[1] ? 4'b0011 : 4'b1100;
            2'd2:    en = 4'b1000 >> off;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    // Replicate the right-justified store item across every lane so the
    // byte enables alone select where it lands.
    function automatic logic [31:0] laneData(input logic [1:0]  size,
                                             input logic [31:0] data);
        logic [31:0] d;
        case (size)
            2'd1:    d = {2{data[15:0]}};
            2'd2:    d = {4{data[7:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    assign reqValid   = memRead | memWrite;
    assign timeoutHit = (toCnt == TO_LAST);

    always_comb begin
        misaligned = 1'b0;
        case (dataSize)
            2'd0:    misaligned = (addr[1:0] != 2'b00);
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = 1'b0;
            default: misaligned = 1'b1;
        endcase
    end

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---- next state and decoded outputs ----
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        busReq    = 1'b0;
        done      = 1'b0;
        rdValid   = 1'b0;
        addrErr   = 1'b0;
        busErr    = 1'b0;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    stall     = 1'b1;
                    stateNext = misaligned ? ERR : REQ;
                end
            end
            REQ: begin
                stall  = 1'b1;
                busReq = 1'b1;
                // Ack in the last allowed cycle still completes normally.
                if (busAck) begin
                    stateNext = DONE;
                end else if (timeoutHit) begin
                    stateNext = ERR;
                end
            end
            DONE: begin
                done      = 1'b1;
                rdValid   = accessLoad;
                stateNext = IDLE;
            end
            ERR: begin
                addrErr   = ~errBus;
                busErr    = errBus;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // ---- request capture, timeout count and load capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toCnt      <= '0;
            accessLoad <= 1'b0;
            errBus     <= 1'b0;
            busWe      <= 1'b0;
            busAddr    <= '0;
            busWrData  <= '0;
            busByteEn  <= '0;
            rdWord     <= '0;
            rdOffset   <= '0;
            rdSize     <= '0;
            rdBitExt   <= 1'b0;
        end else begin
            // Counter is held at zero outside REQ, so it is clear on entry.
            if (state == REQ) begin
                toCnt <= toCnt + 1'b1;
            end else begin
                toCnt <= '0;
            end

            if (state == IDLE && reqValid) begin
                if (misaligned) begin
                    errBus <= 1'b0;
                end else begin
                    accessLoad <= ~memWrite;
                    busWe      <= memWrite;
                    busAddr    <= {addr[31:2], 2'b00};
                    if (memWrite) begin
                        busWrData <= laneData(dataSize, wrData);
                        busByteEn <= laneEnable(dataSize, addr[1:0]);
                    end else begin
                        busWrData <= '0;
                        busByteEn <= 4'b1111;
                        rdOffset  <= addr[1:0];
                        rdSize    <= dataSize;
                        rdBitExt  <= bitExt;
                    end
                end
            end

            if (state == REQ) begin
                if (busAck) begin
                    if (accessLoad) begin
                        rdWord <= busRdData;
                    end
                end else if (timeoutHit) begin
                    errBus <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wrData = '0;
    logic [1:0]  dataSize = '0;
    logic        bitExt = 1'b0;
    logic        stall;
    logic        done;
    logic        addrErr;
    logic        busErr;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWrData;
    logic [3:0]  busByteEn;
    logic        busAck = 1'b0;
    logic [31:0] busRdData = '0;
    logic [31:0] rdWord;
    logic [1:0]  rdOffset;
    logic [1:0]  rdSize;
    logic        rdBitExt;
    logic        rdValid;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .addr      (addr),
        .wrData    (wrData),
        .dataSize  (dataSize),
        .bitExt    (bitExt),
        .stall     (stall),
        .done      (done),
        .addrErr   (addrErr),
        .busErr    (busErr),
        .busReq    (busReq),
        .busWe     (busWe),
        .busAddr   (busAddr),
        .busWrData (busWrData),
        .busByteEn (busByteEn),
        .busAck    (busAck),
        .busRdData (busRdData),
        .rdWord    (rdWord),
        .rdOffset  (rdOffset),
        .rdSize    (rdSize),
        .rdBitExt  (rdBitExt),
        .rdValid   (rdValid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checkCount = 0;
    int failCount  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        checkCount++;
        if (got !== want) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, want, $time);
        end
    endtask

    typedef struct {
        int          endCyc;
        logic        expDone;
        logic        expAddrErr;
        logic        expBusErr;
        logic        expRdValid;
        logic [31:0] word;
        logic [1:0]  off;
        logic [1:0]  sz;
        logic        ext;
    } exp_t;

    exp_t sb[$];

    // Reference view of the decoder-facing registers.
    logic [31:0] mRdWord = '0;
    logic [1:0]  mRdOff  = '0;
    logic [1:0]  mRdSize = '0;
    logic        mRdExt  = 1'b0;

    // Completion monitor: pops one expectation per done/error pulse.
    always @(negedge clk) begin
        if (rst_n && (done || addrErr || busErr)) begin
            if (sb.size() == 0) begin
                checkVal("unexpected_completion", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkVal("done",      {31'd0, done},    {31'd0, e.expDone});
                checkVal("addrErr",   {31'd0, addrErr}, {31'd0, e.expAddrErr});
                checkVal("busErr",    {31'd0, busErr},  {31'd0, e.expBusErr});
                checkVal("rdValid",   {31'd0, rdValid}, {31'd0, e.expRdValid});
                checkVal("endCycle",  cyc,              e.endCyc);
                checkVal("stallEnd",  {31'd0, stall},   32'd0);
                checkVal("busReqEnd", {31'd0, busReq},  32'd0);
                checkVal("rdWord",    rdWord,           e.word);
                checkVal("rdOffset",  {30'd0, rdOffset}, {30'd0, e.off});
                checkVal("rdSize",    {30'd0, rdSize},   {30'd0, e.sz});
                checkVal("rdBitExt",  {31'd0, rdBitExt}, {31'd0, e.ext});
            end
        end
    end

    // One access, request first presented in cycle 0. ackAt = 0 means no ack.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz,
                          input logic ext, input int ackAt,
                          input logic [31:0] rdat, input logic mis,
                          input logic [3:0] expBe, input logic [31:0] expWd);
        exp_t e;
        int   endReq;
        logic isLoad;
        isLoad = ~wr;
        @(posedge clk);
        #1;
        memRead = rd; memWrite = wr; addr = a; wrData = wd;
        dataSize = sz; bitExt = ext;

        endReq = mis ? 0 : ((ackAt >= 1 && ackAt <= TO) ? ackAt : TO);
        e.expDone    = !mis && ackAt >= 1 && ackAt <= TO;
        e.expAddrErr = mis;
        e.expBusErr  = !mis && !e.expDone;
        e.expRdValid = e.expDone && isLoad;
        e.endCyc     = cyc + (mis ? 1 : endReq + 1);
        if (!mis && isLoad) begin
            mRdOff = a[1:0]; mRdSize = sz; mRdExt = ext;
            if (e.expDone) mRdWord = rdat;
        end
        e.word = mRdWord; e.off = mRdOff; e.sz = mRdSize; e.ext = mRdExt;
        sb.push_back(e);

        @(negedge clk);
        checkVal("stallC0",  {31'd0, stall},  32'd1);
        checkVal("busReqC0", {31'd0, busReq}, 32'd0);

        for (int c = 1; c <= TO + 2; c++) begin
            @(posedge clk);
            #1;
            memRead = 1'b0; memWrite = 1'b0;
            busAck    = (c == ackAt);
            busRdData = (c == ackAt) ? rdat : (32'hBAD0_0000 + c);
            @(negedge clk);
            checkVal("busReq", {31'd0, busReq}, {31'd0, (c <= endReq)});
            checkVal("stall",  {31'd0, stall},  {31'd0, (c <= endReq)});
            if (c <= endReq && (c == 1 || c == endReq)) begin
                checkVal("busAddr",   busAddr,   {a[31:2], 2'b00});
                checkVal("busByteEn", {28'd0, busByteEn}, {28'd0, expBe});
                checkVal("busWrData", busWrData, expWd);
                checkVal("busWe",     {31'd0, busWe}, {31'd0, wr});
            end
        end
        busAck = 1'b0;
        checkVal("drain", sb.size(), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_busReq"},   {31'd0, busReq},   0);
        checkVal({tag, "_busWe"},    {31'd0, busWe},    0);
        checkVal({tag, "_busAddr"},  busAddr,           0);
        checkVal({tag, "_busWrData"}, busWrData,        0);
        checkVal({tag, "_busByteEn"}, {28'd0, busByteEn}, 0);
        checkVal({tag, "_rdWord"},   rdWord,            0);
        checkVal({tag, "_rdOffset"}, {30'd0, rdOffset}, 0);
        checkVal({tag, "_rdSize"},   {30'd0, rdSize},   0);
        checkVal({tag, "_rdBitExt"}, {31'd0, rdBitExt}, 0);
        checkVal({tag, "_rdValid"},  {31'd0, rdValid},  0);
        checkVal({tag, "_done"},     {31'd0, done},     0);
        checkVal({tag, "_addrErr"},  {31'd0, addrErr},  0);
        checkVal({tag, "_busErr"},   {31'd0, busErr},   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        // Zero-wait word load.
        access(0, 1, 32'h0000_1000, 32'h0, 2'd0, 1'b0, 1, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0);
        // Byte store, 3 wait states; rd outputs must stay as the load left them.
        access(1, 0, 32'h0000_2003, 32'h0000_00A5, 2'd2, 1'b0, 4, 32'h0, 0, 4'b0001, 32'hA5A5_A5A5);
        // Half load at offset 2, sign-extend.
        access(0, 1, 32'h0000_3002, 32'h0, 2'd1, 1'b0, 2, 32'h1234_ABCD, 0, 4'b1111, 32'h0);
        // Misaligned word, misaligned half, reserved size.
        access(0, 1, 32'h0000_4002, 32'h0, 2'd0, 1'b1, 1, 32'h0, 1, 4'b0000, 32'h0);
        access(0, 1, 32'h0000_4001, 32'h0, 2'd1, 1'b1, 1, 32'h0, 1, 4'b0000, 32'h0);
        access(1, 0, 32'h0000_4000, 32'h0, 2'd3, 1'b0, 1, 32'h0, 1, 4'b0000, 32'h0);
        // Timeout: no ack, then ack in the last allowed cycle.
        access(0, 1, 32'h0000_5008, 32'h0, 2'd0, 1'b1, 0, 32'h0, 0, 4'b1111, 32'h0);
        access(0, 1, 32'h0000_500C, 32'h0, 2'd0, 1'b1, TO, 32'h0BAD_F00D, 0, 4'b1111, 32'h0);
        // Store lane patterns and memWrite priority.
        access(1, 0, 32'h0000_6000, 32'hFFFF_1234, 2'd1, 1'b0, 1, 32'h0, 0, 4'b1100, 32'h1234_1234);
        access(1, 0, 32'h0000_6001, 32'h1234_565A, 2'd2, 1'b0, 2, 32'h0, 0, 4'b0100, 32'h5A5A_5A5A);
        access(1, 1, 32'h0000_6004, 32'hCAFE_F00D, 2'd0, 1'b0, 1, 32'h0, 0, 4'b1111, 32'hCAFE_F00D);
        // Byte load with zero-extend.
        access(0, 1, 32'h0000_7001, 32'h0, 2'd2, 1'b1, 3, 32'h89AB_CDEF, 0, 4'b1111, 32'h0);

        // Reset in the middle of REQ.
        @(posedge clk);
        #1;
        memRead = 1'b1; addr = 32'h0000_8000; dataSize = 2'd0; bitExt = 1'b0;
        @(posedge clk);
        #1;
        memRead = 1'b0;
        @(posedge clk);
        #2;
        checkVal("midReq_busReqBefore", {31'd0, busReq}, 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("midReq");
        checkVal("midReq_stall", {31'd0, stall}, 0);
        mRdWord = '0; mRdOff = '0; mRdSize = '0; mRdExt = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Clean access after reset release.
        access(0, 1, 32'h0000_9006, 32'h0, 2'd1, 1'b1, 2, 32'h5566_7788, 0, 4'b1111, 32'h0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store bus sequencer for the MIPS32 SoC data path, placed between the execute stage and the data-memory bus. It accepts one load or store per request, checks alignment, and builds big-endian byte enables and lane-replicated write data. It runs a req/ack handshake with wait-state and timeout support and stalls the pipeline until completion. For loads it captures the raw memory word and holds the offset, size and extension controls for the downstream read-data decoder, which performs the lane select and sign/zero extension.

## Interface
- TIMEOUT, 255: maximum REQ cycles without busAck before a bus error; legal range 1..65535.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- memRead  in  1  load request
- memWrite  in  1  store request; has priority over memRead if both are high
- addr  in  32  byte address
- wrData  in  32  store data, right-justified
- dataSize  in  2  0 = word, 1 = half, 2 = byte, 3 = reserved
- bitExt  in  1  load extension control, forwarded unchanged (1 = zero-extend, 0 = sign-extend)
- stall  out  1  freeze the pipeline
- done  out  1  one-cycle access-complete pulse
- addrErr  out  1  one-cycle misaligned or reserved-size pulse
- busErr  out  1  one-cycle timeout pulse
- busReq  out  1  bus request
- busWe  out  1  bus write
- busAddr  out  32  word address, {addr[31:2], 2'b00}
- busWrData  out  32  lane-replicated store data
- busByteEn  out  4  byte enables; bit 3 = data[31:24]
- busAck  in  1  bus acknowledge
- busRdData  in  32  bus read word
- rdWord  out  32  captured read word, to the decoder's inData
- rdOffset  out  2  latched addr[1:0], to the decoder's offset
- rdSize  out  2  latched dataSize, to the decoder's dataSize
- rdBitExt  out  1  latched bitExt, to the decoder's bitExt
- rdValid  out  1  one-cycle pulse when rdWord is updated

## Operation
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE, request present, aligned:
  - latch the bus outputs and rd controls; go to REQ.
  - rd controls are latched on loads only.
- IDLE, request present, misaligned: go to ERR with no bus access. Misaligned means any of:
  - half with addr[0] = 1
  - word with addr[1:0] ≠ 0
  - dataSize = 3
- REQ: busReq = 1.
  - busAck = 1: on a load, capture rdWord <= busRdData; go to DONE.
  - Timeout counter reaches TIMEOUT with no busAck: go to ERR and flag busErr.
- DONE: done = 1; rdValid = 1 if the access was a load; go to IDLE.
- ERR: addrErr = 1 or busErr = 1 according to the cause; go to IDLE.
- Byte enables (big-endian lanes):
  - word: 1111
  - half, offset 0: 1100; half, offset 2: 0011
  - byte, offsets 0/1/2/3: 1000 / 0100 / 0010 / 0001
- Store data:
  - word: wrData
  - half: {wrData[15:0], wrData[15:0]}
  - byte: {4{wrData[7:0]}}
- Load bus cycles: busWe = 0, busByteEn = 1111, busWrData = 0.
- stall = (IDLE & (memRead | memWrite)) | REQ. stall is combinational and 0 in DONE and ERR, so the pipeline advances exactly once per access.
- rdWord and the rd controls hold their values until the next accepted load. Stores and errors leave them unchanged.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE; timeout counter = 0.
  - All outputs 0: busReq, busWe, busAddr, busWrData, busByteEn, rdWord, rdOffset, rdSize, rdBitExt, rdValid, done, addrErr, busErr.
  - Reset during REQ drops busReq immediately and abandons the access.
- Cycle timing, request first seen in cycle 0:
  - cycle 0: IDLE, stall = 1.
  - cycle 1: busReq = 1.
  - ack in cycle N ≥ 1: done in cycle N+1.
  - Minimum stall is 2 cycles; zero-wait access latency is 2 cycles.
- Bus outputs are registered and stable throughout REQ. busAck is ignored outside REQ; busRdData is sampled only on the acked cycle.
- Timeout counter:
  - cleared on entry to REQ; counts REQ cycles; width is ceil(log2(TIMEOUT+1)).
  - After TIMEOUT REQ cycles without ack: busReq falls and busErr pulses the next cycle.
  - Ack in the TIMEOUT-th cycle completes normally; ack wins over timeout.
- Misaligned access: addrErr in cycle 1; stall only in cycle 0; no busReq.
- Back-to-back requests: a new request is evaluated in the IDLE cycle after DONE/ERR. There is no idle gap beyond that cycle.

## Test plan
- Reset mid-REQ: assert rst_n = 0 while busReq = 1 -> all outputs 0 the same cycle; the next request after release starts cleanly from IDLE.
- Zero-wait word load: addr = 0x1000, size = 0, busAck in cycle 1 with busRdData = 0xDEADBEEF -> done and rdValid in cycle 2; rdWord = 0xDEADBEEF; rdOffset = 0; stall high in cycles 0–1 only.
- Byte store with 3 wait states: addr = 0x2003, size = 2, wrData = 0x000000A5, ack in cycle 4 -> busAddr = 0x2000, busByteEn = 0001, busWrData = 0xA5A5A5A5, busWe = 1; done in cycle 5; rd outputs unchanged.
- Half load: addr = 0x3002, size = 1, bitExt = 0 -> busByteEn = 1111, rdOffset = 2, rdSize = 1, rdBitExt = 0; rdWord captured from busRdData.
- Misaligned accesses: word at 0x4002 and half at 0x4001 -> addrErr in cycle 1; busReq never asserted; no done pulse.
- Timeout: TIMEOUT = 4, no ack -> busReq high in cycles 1–4, busErr in cycle 5, no done pulse. With ack in cycle 4 instead -> done in cycle 5, no busErr.
